// File: rtl/xorshift_prng_ctrl.sv
// ---------------------------------------------------------------------------
// xorshift_prng_ctrl
//
// Purpose:
//    Sequential wrapper around the combinational xorshift_logic stage. Owns
//    the PRNG state register, handles seeding, steps the generator when a
//    request is accepted, reduces each new draw to an outcome index
//    0..NUM_OUTCOMES-1 with a bit-serial restoring remainder (one draw bit
//    per cycle, MSB first) and returns draw + outcome over a valid/ready
//    response port.
//
// Ports:
//    clk_i         in   1                     clock
//    rst_ni        in   1                     async reset, active low
//    seed_valid_i  in   1                     load seed_i as the new state
//    seed_i        in   PRNG_WIDTH            seed value (zero -> DEFAULT_SEED)
//    req_valid_i   in   1                     request a new draw
//    req_ready_o   out  1                     request accepted on valid&ready
//    rsp_valid_o   out  1                     draw + outcome available
//    rsp_ready_i   in   1                     consumer accepts the response
//    random_o      out  PRNG_WIDTH            raw draw (the new state)
//    outcome_o     out  $clog2(NUM_OUTCOMES)  random_o mod NUM_OUTCOMES
//    busy_o        out  1                     high while reducing or holding
//
// Configuration macro:
//    XORSHIFT_ENTROPY_MIX_EN - when defined, a free-running cycle counter is
//    XORed into the state at every request accept before stepping. When
//    undefined the sequence is fully deterministic from the seed.
// ---------------------------------------------------------------------------

// One xorshift32 step (13 / 17 / 5 triple), purely combinational.
module xorshift_logic #(
   parameter int PRNG_WIDTH = 32
) (
   input  logic [PRNG_WIDTH-1:0] state_i,
   output logic [PRNG_WIDTH-1:0] next_o
);

   logic [PRNG_WIDTH-1:0] step_a;
   logic [PRNG_WIDTH-1:0] step_b;

   // Three shift/xor stages chained in order; each feeds the next.
   always_comb begin
      step_a = state_i ^ (state_i << 13);
      step_b = step_a ^ (step_a >> 17);
      next_o = step_b ^ (step_b << 5);
   end

endmodule

module xorshift_prng_ctrl #(
   parameter int                    PRNG_WIDTH   = 32,
   parameter int                    NUM_OUTCOMES = 20,
   parameter logic [PRNG_WIDTH-1:0] DEFAULT_SEED = 32'h2545F491
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            seed_valid_i,
   input  logic [PRNG_WIDTH-1:0]           seed_i,
   input  logic                            req_valid_i,
   output logic                            req_ready_o,
   output logic                            rsp_valid_o,
   input  logic                            rsp_ready_i,
   output logic [PRNG_WIDTH-1:0]           random_o,
   output logic [$clog2(NUM_OUTCOMES)-1:0] outcome_o,
   output logic                            busy_o
);

   localparam int OW = $clog2(NUM_OUTCOMES);
   localparam int RW = OW + 1;
   localparam int CW = (PRNG_WIDTH > 1) ? $clog2(PRNG_WIDTH) : 1;

   // A modulus below 2 is meaningless and a zero default seed would lock
   // the generator at zero forever, so both are rejected at elaboration.
   generate
      if (NUM_OUTCOMES < 2) begin : g_bad_outcomes
         $error("xorshift_prng_ctrl: NUM_OUTCOMES must be >= 2");
      end
      if (DEFAULT_SEED == '0) begin : g_bad_seed
         $error("xorshift_prng_ctrl: DEFAULT_SEED must be nonzero");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      REDUCE,
      DONE
   } fsm_t;

   fsm_t                  fsm_q;
   logic [PRNG_WIDTH-1:0] state_q;
   logic [PRNG_WIDTH-1:0] random_q;
   logic [RW-1:0]         rem_q;
   logic [CW-1:0]         bit_cnt_q;
   logic                  seed_pend_q;
   logic [PRNG_WIDTH-1:0] seed_pend_val_q;

   logic [PRNG_WIDTH-1:0] seed_eff;
   logic [PRNG_WIDTH-1:0] draw_src;
   logic [PRNG_WIDTH-1:0] draw_in;
   logic [PRNG_WIDTH-1:0] draw_next;
   logic [RW-1:0]         rem_shift;
   logic [RW-1:0]         rem_next;

`ifdef XORSHIFT_ENTROPY_MIX_EN
   logic [PRNG_WIDTH-1:0] cnt_q;
   logic [PRNG_WIDTH-1:0] mixed;

   // Free-running entropy counter; wraps naturally.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
`endif

   // Seed substitution and selection of the state the next draw steps from.
   // A seed arriving in the same cycle as an accepted request wins, so the
   // draw is taken from the freshly seeded state. Zero is never allowed to
   // reach the xorshift stage because it is a fixed point.
   always_comb begin
      seed_eff = (seed_i == '0) ? DEFAULT_SEED : seed_i;
      draw_src = seed_valid_i ? seed_eff : state_q;
`ifdef XORSHIFT_ENTROPY_MIX_EN
      mixed    = draw_src ^ cnt_q;
      draw_in  = (mixed == '0) ? DEFAULT_SEED : mixed;
`else
      draw_in  = draw_src;
`endif
   end

   xorshift_logic #(
      .PRNG_WIDTH(PRNG_WIDTH)
   ) u_xorshift (
      .state_i(draw_in),
      .next_o (draw_next)
   );

   // One step of restoring remainder: shift in the next draw bit and
   // subtract the modulus once if it fits. rem_q stays below NUM_OUTCOMES,
   // so the shifted value always fits in one extra bit.
   always_comb begin
      rem_shift = (rem_q << 1) | RW'(random_q[bit_cnt_q]);
      rem_next  = (rem_shift >= RW'(NUM_OUTCOMES)) ?
                  (rem_shift - RW'(NUM_OUTCOMES)) : rem_shift;
   end

   // Main controller. All outputs are registered. Seeds that arrive while a
   // draw is in flight are parked in seed_pend_q and committed on the same
   // edge that returns to IDLE, so they never disturb the current draw.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fsm_q           <= IDLE;
         state_q         <= DEFAULT_SEED;
         random_q        <= '0;
         rem_q           <= '0;
         bit_cnt_q       <= '0;
         seed_pend_q     <= 1'b0;
         seed_pend_val_q <= '0;
         req_ready_o     <= 1'b1;
         rsp_valid_o     <= 1'b0;
         random_o        <= '0;
         outcome_o       <= '0;
         busy_o          <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (req_valid_i) begin
                  state_q     <= draw_next;
                  random_q    <= draw_next;
                  rem_q       <= '0;
                  bit_cnt_q   <= CW'(PRNG_WIDTH - 1);
                  fsm_q       <= REDUCE;
                  req_ready_o <= 1'b0;
                  busy_o      <= 1'b1;
               end else if (seed_valid_i) begin
                  state_q <= seed_eff;
               end
            end

            REDUCE: begin
               rem_q <= rem_next;
               if (seed_valid_i) begin
                  seed_pend_q     <= 1'b1;
                  seed_pend_val_q <= seed_eff;
               end
               if (bit_cnt_q == '0) begin
                  fsm_q       <= DONE;
                  rsp_valid_o <= 1'b1;
                  random_o    <= random_q;
                  outcome_o   <= rem_next[OW-1:0];
               end else begin
                  bit_cnt_q <= bit_cnt_q - 1'b1;
               end
            end

            DONE: begin
               if (rsp_ready_i) begin
                  fsm_q       <= IDLE;
                  rsp_valid_o <= 1'b0;
                  busy_o      <= 1'b0;
                  req_ready_o <= 1'b1;
                  seed_pend_q <= 1'b0;
                  if (seed_valid_i) begin
                     state_q <= seed_eff;
                  end else if (seed_pend_q) begin
                     state_q <= seed_pend_val_q;
                  end
               end else if (seed_valid_i) begin
                  seed_pend_q     <= 1'b1;
                  seed_pend_val_q <= seed_eff;
               end
            end

            default: begin
               fsm_q       <= IDLE;
               req_ready_o <= 1'b1;
               rsp_valid_o <= 1'b0;
               busy_o      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xorshift_prng_ctrl.sv
// ---------------------------------------------------------------------------
// tb_xorshift_prng_ctrl
//
// Purpose:
//    Directed bench for xorshift_prng_ctrl. Two instances share all inputs:
//    one with the default modulus 20 and one with modulus 7. Expected draws
//    are hand-computed for the fixed cases and produced by a small
//    xorshift32 reference model for the seeded sweep.
// ---------------------------------------------------------------------------
module tb_xorshift_prng_ctrl;

   localparam logic [31:0] DEF_SEED = 32'h2545F491;

   logic        clk;
   logic        rst_n;
   logic        seed_valid;
   logic [31:0] seed;
   logic        req_valid;
   logic        rsp_ready;

   logic        req_ready20;
   logic        rsp_valid20;
   logic [31:0] random20;
   logic [4:0]  outcome20;
   logic        busy20;

   logic        req_ready7;
   logic        rsp_valid7;
   logic [31:0] random7;
   logic [2:0]  outcome7;
   logic        busy7;

   int          n_checks;
   int          n_pass;
   int          cyc;
   int          acc_cyc;
   logic [31:0] mstate;

   xorshift_prng_ctrl #(
      .PRNG_WIDTH  (32),
      .NUM_OUTCOMES(20),
      .DEFAULT_SEED(DEF_SEED)
   ) dut20 (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .seed_valid_i(seed_valid),
      .seed_i      (seed),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready20),
      .rsp_valid_o (rsp_valid20),
      .rsp_ready_i (rsp_ready),
      .random_o    (random20),
      .outcome_o   (outcome20),
      .busy_o      (busy20)
   );

   xorshift_prng_ctrl #(
      .PRNG_WIDTH  (32),
      .NUM_OUTCOMES(7),
      .DEFAULT_SEED(DEF_SEED)
   ) dut7 (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .seed_valid_i(seed_valid),
      .seed_i      (seed),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready7),
      .rsp_valid_o (rsp_valid7),
      .rsp_ready_i (rsp_ready),
      .random_o    (random7),
      .outcome_o   (outcome7),
      .busy_o      (busy7)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference xorshift32 step.
   function automatic logic [31:0] xs32(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

   // Advance one clock and settle 1 ns past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // One comparison: counts it, reports on mismatch.
   task automatic check_output(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   // Present a request (optionally with a seed in the same cycle) and let it
   // be accepted on the next edge.
   task automatic apply_stimulus(input string tag, input logic with_seed,
                                 input logic [31:0] seed_val);
      check_output({tag, ".req_ready"}, 32'(req_ready20), 32'd1);
      req_valid  = 1'b1;
      seed_valid = with_seed;
      seed       = seed_val;
      tick();
      req_valid  = 1'b0;
      seed_valid = 1'b0;
      acc_cyc    = cyc;
      check_output({tag, ".busy"}, {30'd0, busy20, busy7}, 32'd3);
      check_output({tag, ".ready_low"}, {30'd0, req_ready20, req_ready7}, 32'd0);
   endtask

   // Wait (bounded) for the response and check its latency.
   task automatic wait_rsp(input string tag);
      while (!rsp_valid20 && (cyc - acc_cyc) < 100) tick();
      check_output({tag, ".latency"}, 32'(cyc - acc_cyc + 1), 32'd33);
      check_output({tag, ".valid7"}, 32'(rsp_valid7), 32'd1);
   endtask

   // Check the held response and complete the handshake.
   task automatic finish_rsp(input string tag, input logic [31:0] exp_rand,
                             input logic [31:0] exp_o20, input logic [31:0] exp_o7);
      check_output({tag, ".random"}, random20, exp_rand);
      check_output({tag, ".random7"}, random7, exp_rand);
      check_output({tag, ".out20"}, 32'(outcome20), exp_o20);
      check_output({tag, ".out7"}, 32'(outcome7), exp_o7);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check_output({tag, ".idle"}, {29'd0, rsp_valid20, busy20, req_ready20}, 32'd1);
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      cyc        = 0;
      acc_cyc    = 0;
      rst_n      = 1'b0;
      seed_valid = 1'b0;
      seed       = '0;
      req_valid  = 1'b0;
      rsp_ready  = 1'b0;
      mstate     = DEF_SEED;

      // Reset values.
      tick();
      tick();
      check_output("rst.outputs",
                   {27'd0, req_ready20, rsp_valid20, busy20, req_ready7, rsp_valid7},
                   32'h0000_0012);
      check_output("rst.random", random20, 32'd0);
      check_output("rst.outcome", {27'd0, outcome20}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Seed 1 then draw: hand value 0x00042021, mod 20 = 9, mod 7 = 1.
      $display("[TB] seed 1 then request");
      seed_valid = 1'b1;
      seed       = 32'd1;
      tick();
      seed_valid = 1'b0;
      apply_stimulus("seed1", 1'b0, 32'd0);
      wait_rsp("seed1");
      finish_rsp("seed1", 32'h0004_2021, 32'd9, 32'd1);

      // Zero seed falls back to the default: 0xE124B63A, mod 20 = 6, mod 7 = 5.
      $display("[TB] zero seed then request");
      seed_valid = 1'b1;
      seed       = 32'd0;
      tick();
      seed_valid = 1'b0;
      apply_stimulus("seed0", 1'b0, 32'd0);
      wait_rsp("seed0");
      finish_rsp("seed0", 32'hE124_B63A, 32'd6, 32'd5);
      mstate = 32'hE124_B63A;

      // Hold DONE for 50 cycles with the requester pushing: nothing moves.
      $display("[TB] response held under backpressure");
      mstate = xs32(mstate);
      apply_stimulus("hold", 1'b0, 32'd0);
      req_valid = 1'b1;
      wait_rsp("hold");
      begin
         int bad;
         bad = 0;
         for (int i = 0; i < 50; i++) begin
            if (rsp_valid20 !== 1'b1 || random20 !== mstate ||
                32'(outcome20) !== (mstate % 20) || req_ready20 !== 1'b0 ||
                busy20 !== 1'b1)
               bad++;
            tick();
         end
         check_output("hold.stable_cycles_bad", 32'(bad), 32'd0);
      end
      req_valid = 1'b0;
      finish_rsp("hold", mstate, mstate % 20, mstate % 7);

      // Seed pulsed mid-REDUCE: current draw untouched, next draw from seed 1.
      $display("[TB] seed during reduce");
      mstate = xs32(mstate);
      apply_stimulus("midseed", 1'b0, 32'd0);
      for (int i = 0; i < 5; i++) tick();
      seed_valid = 1'b1;
      seed       = 32'd1;
      tick();
      seed_valid = 1'b0;
      wait_rsp("midseed");
      finish_rsp("midseed", mstate, mstate % 20, mstate % 7);
      apply_stimulus("afterseed", 1'b0, 32'd0);
      wait_rsp("afterseed");
      finish_rsp("afterseed", 32'h0004_2021, 32'd9, 32'd1);

      // Seed and request in the same IDLE cycle: draw from the new seed.
      $display("[TB] seed and request together");
      apply_stimulus("both", 1'b1, 32'd1);
      wait_rsp("both");
      finish_rsp("both", 32'h0004_2021, 32'd9, 32'd1);

      // Reset at REDUCE cycle 10 with a seed pending: everything cleared.
      $display("[TB] reset during reduce");
      apply_stimulus("rstmid", 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) tick();
      seed_valid = 1'b1;
      seed       = 32'h0000_1234;
      tick();
      seed_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_output("rstmid.flags",
                   {27'd0, req_ready20, rsp_valid20, busy20, req_ready7, busy7},
                   32'h0000_0012);
      check_output("rstmid.random", random20, 32'd0);
      check_output("rstmid.outcome", {27'd0, outcome20}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      apply_stimulus("postrst", 1'b0, 32'd0);
      wait_rsp("postrst");
      finish_rsp("postrst", 32'hE124_B63A, 32'd6, 32'd5);
      mstate = 32'hE124_B63A;

      // Seeded sweep against the reference model.
      $display("[TB] seeded sweep");
      for (int s = 0; s < 20; s++) begin
         logic [31:0] sv;
         sv = $urandom;
         if (s == 0) sv = 32'hFFFF_FFFF;
         seed_valid = 1'b1;
         seed       = sv;
         tick();
         seed_valid = 1'b0;
         mstate = (sv == 32'd0) ? DEF_SEED : sv;
         for (int d = 0; d < 5; d++) begin
            mstate = xs32(mstate);
            apply_stimulus("sweep", 1'b0, 32'd0);
            wait_rsp("sweep");
            check_output("sweep.nonzero", 32'(random20 != 32'd0), 32'd1);
            finish_rsp("sweep", mstate, mstate % 20, mstate % 7);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
